// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// the NOP encoding used for pipeline bubbles, and the fetch FSM states.
package if_fetch_unit_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned INSTR_W_DEF = 32;

    // A bubble in IF/ID carries an all-zeros instruction word.
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

    // REQ: request outstanding at PC. HELD: a returned word waits in the skid buffer.
    typedef enum logic {
        FS_REQ  = 1'b0,
        FS_HELD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a new {pc+4, instruction, valid} entry,
// inserts a bubble, or holds its contents. Bubble wins over load.
module if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic               bubble_i,
    input  logic [ADDR_W-1:0]  pc4_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [ADDR_W-1:0]  pc4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc4_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    // Register update: bubble clears the entry, load captures, otherwise hold.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc4_q   <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            pc4_q   <= '0;
            instr_q <= INSTR_W'(NOP_INSTR);
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc4_q   <= pc4_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, talks to a variable-latency
// instruction memory, parks a returned word in a skid buffer while decode
// is frozen, and redirects on a taken branch from execute.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned      ADDR_W   = ADDR_W_DEF,
    parameter int unsigned      INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               valid_out
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  buf_pc4_q, buf_pc4_d;
    logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0]  pc_plus4;

    logic               ifid_load;
    logic               ifid_bubble;
    logic [ADDR_W-1:0]  ifid_pc4;
    logic [INSTR_W-1:0] ifid_instr;

    // Wraps silently modulo 2^ADDR_W.
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Request is only driven in REQ and is forced low while reset is held.
    assign imem_req  = rst && (state_q == FS_REQ);
    assign imem_addr = pc_q;

    // Next-state and IF/ID control: branch beats freeze beats normal flow.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_pc4_d   = buf_pc4_q;
        buf_instr_d = buf_instr_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_pc4    = pc_plus4;
        ifid_instr  = imem_rdata;

        if (branch_taken) begin
            // Any word returning this cycle belongs to the wrong path.
            pc_d        = branch_address;
            state_d     = FS_REQ;
            buf_pc4_d   = '0;
            buf_instr_d = '0;
            ifid_bubble = 1'b1;
        end else begin
            unique case (state_q)
                FS_REQ: begin
                    if (imem_ready) begin
                        pc_d = pc_plus4;
                        if (freeze) begin
                            buf_pc4_d   = pc_plus4;
                            buf_instr_d = imem_rdata;
                            state_d     = FS_HELD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!freeze) begin
                        ifid_bubble = 1'b1;
                    end
                end
                FS_HELD: begin
                    if (!freeze) begin
                        ifid_load  = 1'b1;
                        ifid_pc4   = buf_pc4_q;
                        ifid_instr = buf_instr_q;
                        state_d    = FS_REQ;
                    end
                end
                default: state_d = FS_REQ;
            endcase
        end
    end

    // State, PC and skid buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FS_REQ;
            pc_q        <= RESET_PC;
            buf_pc4_q   <= '0;
            buf_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_pc4_q   <= buf_pc4_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n_i  (rst),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc4_i    (ifid_pc4),
        .instr_i  (ifid_instr),
        .pc4_o    (pc_out),
        .instr_o  (instruction_out),
        .valid_o  (valid_out)
    );

endmodule
